// File: rtl/evm_pkg.sv
// evm_pkg: shared defaults and scan state type for the EVM tally path
package evm_pkg;
    localparam int EVM_NUM_CAND = 8;
    localparam int EVM_CNT_W = 8;
    localparam int EVM_ID_W = 4;
    typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/winner_scan_seq_if.sv
// winner_scan_seq_if: request/result bundle between the vote-counter bank and the winner scanner
interface winner_scan_seq_if
    import evm_pkg::*;
#(
    parameter int NUM_CAND = EVM_NUM_CAND,
    parameter int CNT_W = EVM_CNT_W,
    parameter int ID_W = EVM_ID_W
);
    logic start;
    logic [NUM_CAND-1:0] cand_valid;
    logic [NUM_CAND*ID_W-1:0] candidate_numbers;
    logic [NUM_CAND*CNT_W-1:0] vote_counts;
    logic busy;
    logic done;
    logic [ID_W-1:0] winner_candidate;
    logic [CNT_W-1:0] winner_vote_count;
    logic tie;
    logic no_winner;
    modport master (
        output start, cand_valid, candidate_numbers, vote_counts,
        input busy, done, winner_candidate, winner_vote_count, tie, no_winner
    );
    modport slave (
        input start, cand_valid, candidate_numbers, vote_counts,
        output busy, done, winner_candidate, winner_vote_count, tie, no_winner
    );
endinterface

// File: rtl/vote_compare_step.sv
// vote_compare_step: folds one candidate slot into the running maximum, keeping the earlier slot on ties
module vote_compare_step #(
    parameter int CNT_W = 8,
    parameter int ID_W = 4
) (
    input  logic [CNT_W-1:0] cur_max,
    input  logic [ID_W-1:0]  cur_id,
    input  logic             cur_tie,
    input  logic             cur_found,
    input  logic             valid,
    input  logic [ID_W-1:0]  num,
    input  logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] nxt_max,
    output logic [ID_W-1:0]  nxt_id,
    output logic             nxt_tie,
    output logic             nxt_found
);
    logic take;
    assign take = valid && (!cur_found || count > cur_max);
    assign nxt_max = take ? count : cur_max;
    assign nxt_id = take ? num : cur_id;
    assign nxt_found = cur_found | valid;
    assign nxt_tie = take ? 1'b0 : (valid && count == cur_max) ? 1'b1 : cur_tie;
endmodule

// File: rtl/winner_scan_seq.sv
// winner_scan_seq: snapshots the tally on start and scans one slot per cycle for the highest count
module winner_scan_seq
    import evm_pkg::*;
#(
    parameter int NUM_CAND = EVM_NUM_CAND,
    parameter int CNT_W = EVM_CNT_W,
    parameter int ID_W = EVM_ID_W
) (
    input logic clk,
    input logic rst_n,
    winner_scan_seq_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_CAND);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CAND - 1);
    state_t state;
    logic [IDX_W-1:0] idx;
    logic [NUM_CAND-1:0] snap_valid;
    logic [NUM_CAND*ID_W-1:0] snap_num;
    logic [NUM_CAND*CNT_W-1:0] snap_cnt;
    logic [CNT_W-1:0] run_max, nxt_max;
    logic [ID_W-1:0] run_id, nxt_id;
    logic run_tie, nxt_tie, run_found, nxt_found;

    vote_compare_step #(.CNT_W(CNT_W), .ID_W(ID_W)) u_step (
        .cur_max(run_max),
        .cur_id(run_id),
        .cur_tie(run_tie),
        .cur_found(run_found),
        .valid(snap_valid[idx]),
        .num(snap_num[idx*ID_W +: ID_W]),
        .count(snap_cnt[idx*CNT_W +: CNT_W]),
        .nxt_max(nxt_max),
        .nxt_id(nxt_id),
        .nxt_tie(nxt_tie),
        .nxt_found(nxt_found)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= '0;
            snap_valid <= '0;
            snap_num <= '0;
            snap_cnt <= '0;
            run_max <= '0;
            run_id <= '0;
            run_tie <= 1'b0;
            run_found <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.winner_candidate <= '0;
            bus.winner_vote_count <= '0;
            bus.tie <= 1'b0;
            bus.no_winner <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    state <= SCAN;
                    bus.busy <= 1'b1;
                    snap_valid <= bus.cand_valid;
                    snap_num <= bus.candidate_numbers;
                    snap_cnt <= bus.vote_counts;
                    run_max <= '0;
                    run_id <= '0;
                    run_tie <= 1'b0;
                    run_found <= 1'b0;
                    idx <= '0;
                end
            end else begin
                run_max <= nxt_max;
                run_id <= nxt_id;
                run_tie <= nxt_tie;
                run_found <= nxt_found;
                idx <= idx + 1'b1;
                if (idx == LAST) begin
                    // running max/id stay zero when no slot was valid, so they publish directly
                    state <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    bus.winner_candidate <= nxt_id;
                    bus.winner_vote_count <= nxt_max;
                    bus.tie <= nxt_tie;
                    bus.no_winner <= !nxt_found || nxt_max == '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_winner_scan_seq.sv
// tb_winner_scan_seq: directed and random scans checked against a whole-array winner model
module tb_winner_scan_seq;
    import evm_pkg::*;
    localparam int N = EVM_NUM_CAND;
    localparam int CW = EVM_CNT_W;
    localparam int IW = EVM_ID_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    winner_scan_seq_if #(.NUM_CAND(N), .CNT_W(CW), .ID_W(IW)) bus ();
    winner_scan_seq #(.NUM_CAND(N), .CNT_W(CW), .ID_W(IW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic v, input int num, input int cnt);
        bus.cand_valid[i] = v;
        bus.candidate_numbers[i*IW +: IW] = IW'(num);
        bus.vote_counts[i*CW +: CW] = CW'(cnt);
    endtask

    // Winner = highest count among valid slots, lowest slot on equality; tie counts every valid slot at that value
    task automatic model(output logic [IW-1:0] w, output logic [CW-1:0] c, output logic t, output logic nw);
        int best = -1;
        int best_cnt = 0;
        int eq = 0;
        for (int i = 0; i < N; i++)
            if (bus.cand_valid[i] && (best < 0 || int'(bus.vote_counts[i*CW +: CW]) > best_cnt)) begin
                best = i;
                best_cnt = int'(bus.vote_counts[i*CW +: CW]);
            end
        for (int i = 0; i < N; i++)
            if (bus.cand_valid[i] && int'(bus.vote_counts[i*CW +: CW]) == best_cnt) eq++;
        w = best < 0 ? '0 : bus.candidate_numbers[best*IW +: IW];
        c = CW'(best_cnt);
        t = best >= 0 && eq > 1;
        nw = best < 0 || best_cnt == 0;
    endtask

    task automatic scan(input string tag, input bit hold, input bit poke, input bit scramble);
        logic [IW-1:0] ew;
        logic [CW-1:0] ec;
        logic et, en;
        int k;
        model(ew, ec, et, en);
        bus.start = 1'b1;
        tick();
        bus.start = hold;
        check({tag, "_busy"}, 32'(bus.busy), 1);
        k = 0;
        while (k < 40) begin
            k++;
            if (poke) bus.start = hold || k == 3;
            if (scramble && k == 2)
                for (int i = 0; i < N; i++) set_slot(i, ~bus.cand_valid[i], int'($urandom), int'($urandom));
            tick();
            if (bus.done) break;
        end
        bus.start = hold;
        check({tag, "_lat"}, 32'(k), N);
        check({tag, "_idle"}, 32'(bus.busy), 0);
        check({tag, "_win"}, 32'(bus.winner_candidate), 32'(ew));
        check({tag, "_cnt"}, 32'(bus.winner_vote_count), 32'(ec));
        check({tag, "_tie"}, 32'(bus.tie), 32'(et));
        check({tag, "_nowin"}, 32'(bus.no_winner), 32'(en));
        if (!hold) begin
            tick();
            check({tag, "_donefall"}, 32'(bus.done), 0);
            check({tag, "_noqueue"}, 32'(bus.busy), 0);
        end
    endtask

    initial begin
        int seen;
        int base [N] = '{3, 9, 1, 9, 0, 2, 5, 4};
        bus.start = 1'b0;
        bus.cand_valid = '0;
        bus.candidate_numbers = '0;
        bus.vote_counts = '0;
        tick();
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done || bus.busy) seen++;
        end
        check("rst_activity", 32'(seen), 0);
        check("rst_win", 32'(bus.winner_candidate), 0);
        check("rst_cnt", 32'(bus.winner_vote_count), 0);
        check("rst_tie", 32'(bus.tie), 0);
        check("rst_nowin", 32'(bus.no_winner), 0);

        for (int i = 0; i < N; i++) set_slot(i, 1'b1, i + 1, base[i]);
        scan("all_valid", 0, 0, 0);
        check("all_valid_const", 32'(bus.winner_candidate), 2);
        bus.cand_valid = 8'b1111_0101;
        scan("masked", 0, 0, 0);
        bus.cand_valid = '0;
        scan("none_valid", 0, 0, 0);
        for (int i = 0; i < N; i++) set_slot(i, 1'b1, i + 1, 0);
        scan("all_zero", 0, 0, 0);
        for (int i = 0; i < N; i++) set_slot(i, 1'b1, i + 1, i == N - 1 ? 255 : 254);
        scan("top_count", 0, 0, 0);

        for (int i = 0; i < N; i++) set_slot(i, 1'b1, i + 1, base[i]);
        scan("mid_start", 0, 1, 0);
        scan("b2b_a", 1, 0, 1);
        scan("b2b_b", 0, 0, 0);

        for (int i = 0; i < N; i++) set_slot(i, 1'b1, i + 1, base[i]);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_win", 32'(bus.winner_candidate), 0);
        check("abort_cnt", 32'(bus.winner_vote_count), 0);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) seen++;
        end
        check("abort_nodone", 32'(seen), 0);

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++)
                set_slot(i, $urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
                         r % 3 == 0 ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3)));
            scan("rand", 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
